// File: rtl/led_pkg.sv
// Shared mode codes for the LED pattern generator and the helper that orders them.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BINARY  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_BLINK:   return MODE_CHASE;
      MODE_CHASE:   return MODE_BINARY;
      MODE_BINARY:  return MODE_BREATHE;
      default:      return MODE_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debounce for the mode button; emits a
// one-cycle press pulse on each debounced 0->1 transition (release is silent).
module button_debounce #(
  parameter int DEB_W = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             press_q;
  logic [DEB_W-1:0] deb_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Any return to agreement restarts the qualification window.
      if (sync2_q == stable_q) begin
        deb_cnt_q <= '0;
      end else if (&deb_cnt_q) begin
        stable_q  <= sync2_q;
        deb_cnt_q <= '0;
        press_q   <= sync2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_ONE;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Four-mode LED pattern generator: blink, chase, binary count and breathe,
// advanced by a debounced button. LED and MODE are registered outputs.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24,
  parameter int PWM_W  = 8,
  parameter int DEB_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BTN,
  output logic [NUM_CH-1:0] LED,
  output logic [MODE_W-1:0] MODE
);

  localparam int                STEP_W   = CNT_W - PWM_W - 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_CH-1:0] POS_INIT = NUM_CH'(1);
  localparam logic [PWM_W-1:0]  DUTY_ONE = PWM_W'(1);
  localparam logic [PWM_W-1:0]  DUTY_MAX = {PWM_W{1'b1}};

  logic [CNT_W-1:0]  cnt_q;
  mode_e             mode_q;
  logic [NUM_CH-1:0] pos_q;
  logic [PWM_W-1:0]  duty_q;
  logic              dir_up_q;
  logic [NUM_CH-1:0] led_d;
  logic [NUM_CH-1:0] led_q;
  logic [MODE_W-1:0] mode_out_q;

  logic              press;
  logic              tick;
  logic              step;

  button_debounce #(.DEB_W(DEB_W)) u_debounce (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .btn_i   (BTN),
    .press_o (press)
  );

  assign tick = &cnt_q;
  assign step = &cnt_q[STEP_W-1:0];

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_BLINK:   led_d = {NUM_CH{cnt_q[CNT_W-1]}};
      MODE_CHASE:   led_d = pos_q;
      MODE_BINARY:  led_d = cnt_q[CNT_W-1 -: NUM_CH];
      MODE_BREATHE: led_d = {NUM_CH{cnt_q[PWM_W-1:0] < duty_q}};
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q      <= '0;
      mode_q     <= MODE_BLINK;
      pos_q      <= POS_INIT;
      duty_q     <= '0;
      dir_up_q   <= 1'b1;
      led_q      <= '0;
      mode_out_q <= '0;
    end else begin
      cnt_q      <= cnt_q + CNT_ONE;
      led_q      <= led_d;
      mode_out_q <= mode_q;
      // A press re-seeds the chase and breathe state, beating any same-cycle tick/step.
      if (press) begin
        mode_q   <= next_mode(mode_q);
        pos_q    <= POS_INIT;
        duty_q   <= '0;
        dir_up_q <= 1'b1;
      end else begin
        if (mode_q == MODE_CHASE && tick) begin
          pos_q <= (pos_q << 1) | (pos_q >> (NUM_CH - 1));
        end
        if (mode_q == MODE_BREATHE && step) begin
          if (dir_up_q) begin
            if (duty_q == DUTY_MAX) begin
              dir_up_q <= 1'b0;
              duty_q   <= DUTY_MAX - DUTY_ONE;
            end else begin
              duty_q <= duty_q + DUTY_ONE;
            end
          end else begin
            if (duty_q == '0) begin
              dir_up_q <= 1'b1;
              duty_q   <= DUTY_ONE;
            end else begin
              duty_q <= duty_q - DUTY_ONE;
            end
          end
        end
      end
    end
  end

  assign LED  = led_q;
  assign MODE = mode_out_q;

endmodule
